lt24_pixel_writer: RTL
======================

LT24_PIXEL_WRITER -- requirements
Module: lt24_pixel_writer

Interface
REQ-001 Parameter WIDTH, 240, LCD columns.
REQ-002 Parameter HEIGHT, 320, LCD rows.
REQ-003 clock  in  1  single clock; all logic on rising edge.
REQ-004 globalReset_n  in  1  reset, asynchronous and active-low.
REQ-005 xAddr  in  8  pixel column.
REQ-006 yAddr  in  9  pixel row.
REQ-007 pixelData  in  16  RGB565 pixel.
REQ-008 pixelWrite  in  1  pixel request.
REQ-009 pixelReady  out  1  block can accept a pixel.
REQ-010 LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS  out  1 each  LCD 8080-bus strobes; RS=0 command, RS=1 data.
REQ-011 LT24Data  out  16  LCD data bus.

Function
REQ-012 Pixel accept SHALL occur on the edge where pixelWrite=1 and pixelReady=1; xAddr, yAddr and pixelData SHALL be captured there, and pixelReady SHALL be 0 from the next cycle until the transaction completes.
REQ-013 Each bus write SHALL take 2 cycles: phase A with CS_n=0, Wr_n=0, RS and Data valid; phase B with Wr_n=1 and RS/Data held. CS_n SHALL stay 0 across all writes of a transaction.
REQ-014 LT24Rd_n SHALL be constant 1.
REQ-015 The state machine SHALL have states IDLE, ADDR, PIXEL. IDLE asserts pixelReady. Accept goes to ADDR if the pixel is non-sequential, otherwise to PIXEL. ADDR goes to PIXEL after its last write. PIXEL goes to IDLE after its write.
REQ-016 The ADDR sequence SHALL be 11 writes, each byte on Data[7:0] with Data[15:8]=0: cmd 0x2A; data x[15:8], x[7:0], (WIDTH-1)[15:8], (WIDTH-1)[7:0]; cmd 0x2B; data y[15:8], y[7:0], (HEIGHT-1)[15:8], (HEIGHT-1)[7:0]; cmd 0x2C.
REQ-017 PIXEL SHALL be one data write (RS=1) of the full 16-bit pixelData.
REQ-018 A pixel SHALL be sequential only if the history flag is valid and either (y==prevY and x==prevX+1) or (x==0, y==prevY+1, prevX==WIDTH-1, and the stored window start column is 0).
REQ-019 The history flag SHALL be cleared by reset; each completed PIXEL SHALL store prevX, prevY and set the flag. Each ADDR SHALL store the window start column = x.
REQ-020 A pixel at (WIDTH-1, HEIGHT-1) followed by (0,0) SHALL be non-sequential.
REQ-021 Transaction latency from accept to pixelReady=1: 24 cycles non-sequential, 2 cycles sequential.
REQ-022 A pixel with x>=WIDTH or y>=HEIGHT SHALL be accepted and discarded: no bus activity, history flag cleared, pixelReady=1 again on the next cycle.
REQ-023 When idle, CS_n SHALL return to 1 for at least one cycle, and Wr_n=1, RS=1.
REQ-024 pixelWrite=0 in IDLE SHALL leave all outputs stable.

Reset
REQ-025 While globalReset_n=0: pixelReady=0, Wr_n=1, Rd_n=1, CS_n=1, RS=1, Data=0, state=IDLE, history flag cleared.
REQ-026 pixelReady SHALL rise on the first clock edge after globalReset_n deasserts.
REQ-027 Reset mid-transaction SHALL abort immediately to the reset values, and the next pixel SHALL take the full ADDR sequence.

Configuration
REQ-028 Macro LT24_SEQ_BURST_EN: if defined, sequential pixels skip ADDR per REQ-018. If undefined, every in-range pixel SHALL run ADDR then PIXEL (24-cycle latency), the history and window registers SHALL be absent, and all other behaviour is unchanged.

Verification
REQ-029 Release reset, write (5,7)=0xF800 -> 12 writes: 0x2A,0,5,0,0xEF,0x2B,0,7,1,0x3F,0x2C, then 0xF800 with RS=1; pixelReady low for 24 cycles.
REQ-030 After REQ-029, write (6,7)=0x07E0 -> a single data write of 0x07E0, latency 2 (with LT24_SEQ_BURST_EN); full 12 writes without it.
REQ-031 Sweep full frame (0,0)..(239,319) with pixelWrite held 1 -> exactly one ADDR sequence, 76800 data writes, bus data equal to the stimulus; then (0,0) again -> new ADDR sequence.
REQ-032 Write (240,0), then (0,400) -> no Wr_n pulses, pixelReady back high after 1 cycle each; next valid pixel gets a full ADDR sequence.
REQ-033 Assert globalReset_n=0 during write 6 of an ADDR sequence -> outputs at reset values in the same cycle; after release, (6,7) gets a full ADDR sequence.
REQ-034 Write (239,3) with window start 0, then (0,4) -> sequential, single data write; repeat with window start 10 -> full ADDR sequence.

Source files
------------

// File: rtl/lt24_pixel_writer.sv
// ---------------------------------------------------------------------------
// lt24_pixel_writer
//
// Purpose:
//   Accepts single pixels (column, row, RGB565 colour) and writes them to an
//   LT24 LCD controller over its 8080-style parallel bus.  A non-sequential
//   pixel is preceded by a full address-window setup:
//     0x2A, x hi, x lo, (WIDTH-1) hi, (WIDTH-1) lo,
//     0x2B, y hi, y lo, (HEIGHT-1) hi, (HEIGHT-1) lo,
//     0x2C
//   and is followed by one 16-bit data write.  Each bus write is two cycles:
//   phase A (Wr_n low, RS/Data valid) then phase B (Wr_n high, RS/Data held).
//   Chip select stays low for the whole transaction and goes high whenever
//   the block is idle.  Out-of-range pixels are swallowed without bus
//   activity.
//
// Configuration:
//   LT24_SEQ_BURST_EN - when defined, a pixel that continues the previous
//   one in raster order (next column, or wrap to column 0 of the next row
//   when the window was opened at column 0) skips the address setup and is
//   written with a single data write.  When undefined, every in-range pixel
//   gets the full setup and no history registers exist.
//
// Ports:
//   clock          in   single clock, rising edge
//   globalReset_n  in   asynchronous active-low reset
//   xAddr[7:0]     in   pixel column
//   yAddr[8:0]     in   pixel row
//   pixelData[15:0]in   RGB565 colour
//   pixelWrite     in   pixel request (accepted when pixelReady is high)
//   pixelReady     out  block can accept a pixel
//   LT24Wr_n       out  write strobe, active low
//   LT24Rd_n       out  read strobe, tied inactive
//   LT24CS_n       out  chip select, active low
//   LT24RS         out  register select: 0 command, 1 data
//   LT24Data[15:0] out  LCD data bus
// ---------------------------------------------------------------------------
module lt24_pixel_writer #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic        clock,
    input  logic        globalReset_n,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic [15:0] LT24Data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        PIXEL = 2'd2
    } state_t;

    localparam logic [15:0] LAST_COL = 16'(WIDTH - 1);
    localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);
    localparam logic [8:0]  X_LIMIT  = 9'(WIDTH);
    localparam logic [9:0]  Y_LIMIT  = 10'(HEIGHT);
    localparam logic [3:0]  LAST_IDX = 4'd10;

    state_t      state_r;
    logic [3:0]  wrIdx_r;     // index of the current address-setup write
    logic        phaseB_r;    // current bus write is in its hold phase
    logic [7:0]  xLatch_r;
    logic [8:0]  yLatch_r;
    logic [15:0] pixel_r;

    logic        accept_s;
    logic        inRange_s;
    logic        seq_s;

    // Returns {RS, Data} for write number idx of the address-window setup.
    function automatic logic [16:0] addrWord(input logic [3:0] idx,
                                             input logic [7:0] x,
                                             input logic [8:0] y);
        logic [15:0] xw;
        logic [15:0] yw;
        xw = {8'h00, x};
        yw = {7'h00, y};
        case (idx)
            4'd0:    addrWord = {1'b0, 16'h002A};
            4'd1:    addrWord = {1'b1, 8'h00, xw[15:8]};
            4'd2:    addrWord = {1'b1, 8'h00, xw[7:0]};
            4'd3:    addrWord = {1'b1, 8'h00, LAST_COL[15:8]};
            4'd4:    addrWord = {1'b1, 8'h00, LAST_COL[7:0]};
            4'd5:    addrWord = {1'b0, 16'h002B};
            4'd6:    addrWord = {1'b1, 8'h00, yw[15:8]};
            4'd7:    addrWord = {1'b1, 8'h00, yw[7:0]};
            4'd8:    addrWord = {1'b1, 8'h00, LAST_ROW[15:8]};
            4'd9:    addrWord = {1'b1, 8'h00, LAST_ROW[7:0]};
            4'd10:   addrWord = {1'b0, 16'h002C};
            default: addrWord = {1'b0, 16'h002C};
        endcase
    endfunction

    assign LT24Rd_n = 1'b1;
    assign accept_s = pixelWrite & pixelReady;

`ifdef LT24_SEQ_BURST_EN
    logic       histValid_r;  // prevX_r/prevY_r describe the last written pixel
    logic [7:0] prevX_r;
    logic [8:0] prevY_r;
    logic [7:0] winStart_r;   // column the current address window starts at

    // History of the last completed pixel and of the open window.
    always_ff @(posedge clock or negedge globalReset_n) begin
        if (!globalReset_n) begin
            histValid_r <= 1'b0;
            prevX_r     <= 8'd0;
            prevY_r     <= 9'd0;
            winStart_r  <= 8'd0;
        end else if (state_r == IDLE && accept_s) begin
            if (!inRange_s) begin
                histValid_r <= 1'b0;
            end else if (!seq_s) begin
                winStart_r <= xAddr;
            end
        end else if (state_r == PIXEL && phaseB_r) begin
            prevX_r     <= xLatch_r;
            prevY_r     <= yLatch_r;
            histValid_r <= 1'b1;
        end
    end
`endif

    // Range check and raster-continuation detection for the offered pixel.
    always_comb begin
        inRange_s = 1'b0;
        seq_s     = 1'b0;
        if (({1'b0, xAddr} < X_LIMIT) && ({1'b0, yAddr} < Y_LIMIT)) begin
            inRange_s = 1'b1;
        end else begin
            inRange_s = 1'b0;
        end
`ifdef LT24_SEQ_BURST_EN
        // Wrap to the next row only continues the window if it was opened
        // at column 0; otherwise the controller would wrap to winStart_r.
        seq_s = histValid_r &&
                ((({1'b0, yAddr} == {1'b0, prevY_r}) &&
                  ({1'b0, xAddr} == ({1'b0, prevX_r} + 9'd1))) ||
                 ((xAddr == 8'd0) &&
                  ({1'b0, yAddr} == ({1'b0, prevY_r} + 10'd1)) &&
                  ({1'b0, prevX_r} == LAST_COL[8:0]) &&
                  (winStart_r == 8'd0)));
`else
        seq_s = 1'b0;
`endif
    end

    // Transaction state machine driving the registered LCD bus outputs.
    always_ff @(posedge clock or negedge globalReset_n) begin
        if (!globalReset_n) begin
            state_r    <= IDLE;
            pixelReady <= 1'b0;
            LT24Wr_n   <= 1'b1;
            LT24CS_n   <= 1'b1;
            LT24RS     <= 1'b1;
            LT24Data   <= 16'h0000;
            wrIdx_r    <= 4'd0;
            phaseB_r   <= 1'b0;
            xLatch_r   <= 8'd0;
            yLatch_r   <= 9'd0;
            pixel_r    <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        pixelReady <= 1'b0;
                        xLatch_r   <= xAddr;
                        yLatch_r   <= yAddr;
                        pixel_r    <= pixelData;
                        phaseB_r   <= 1'b0;
                        if (!inRange_s) begin
                            // Swallowed: stay idle, ready returns next cycle.
                            state_r <= IDLE;
                        end else if (seq_s) begin
                            state_r  <= PIXEL;
                            LT24CS_n <= 1'b0;
                            LT24Wr_n <= 1'b0;
                            LT24RS   <= 1'b1;
                            LT24Data <= pixelData;
                        end else begin
                            state_r  <= ADDR;
                            wrIdx_r  <= 4'd0;
                            LT24CS_n <= 1'b0;
                            LT24Wr_n <= 1'b0;
                            {LT24RS, LT24Data} <= addrWord(4'd0, xAddr, yAddr);
                        end
                    end else begin
                        pixelReady <= 1'b1;
                        LT24CS_n   <= 1'b1;
                        LT24Wr_n   <= 1'b1;
                        LT24RS     <= 1'b1;
                    end
                end
                ADDR: begin
                    if (!phaseB_r) begin
                        LT24Wr_n <= 1'b1;
                        phaseB_r <= 1'b1;
                    end else if (wrIdx_r == LAST_IDX) begin
                        state_r  <= PIXEL;
                        LT24Wr_n <= 1'b0;
                        LT24RS   <= 1'b1;
                        LT24Data <= pixel_r;
                        phaseB_r <= 1'b0;
                    end else begin
                        wrIdx_r  <= wrIdx_r + 4'd1;
                        LT24Wr_n <= 1'b0;
                        phaseB_r <= 1'b0;
                        {LT24RS, LT24Data} <= addrWord(wrIdx_r + 4'd1, xLatch_r, yLatch_r);
                    end
                end
                PIXEL: begin
                    if (!phaseB_r) begin
                        LT24Wr_n <= 1'b1;
                        phaseB_r <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        LT24CS_n   <= 1'b1;
                        LT24Wr_n   <= 1'b1;
                        LT24RS     <= 1'b1;
                        pixelReady <= 1'b1;
                        phaseB_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    pixelReady <= 1'b0;
                    LT24CS_n   <= 1'b1;
                    LT24Wr_n   <= 1'b1;
                    LT24RS     <= 1'b1;
                    phaseB_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule
